cpu_mem_bridge: RTL and testbench



---
 rtl/cpu_mem_bridge_pkg.sv | 19 +
 rtl/cpu_mem_bridge_mem_req_arb.sv | 48 ++++
 rtl/cpu_mem_bridge.sv | 130 +++++++++++++
 tb/tb_cpu_mem_bridge.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_bridge_pkg
// Purpose  : Shared FSM state and request-select encodings for the bridge.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_mem_bridge_pkg;

  localparam int unsigned c_state_w = 2;

  localparam logic [c_state_w-1:0] c_st_idle = 2'd0;
  localparam logic [c_state_w-1:0] c_st_req  = 2'd1;
  localparam logic [c_state_w-1:0] c_st_resp = 2'd2;

  localparam logic c_sel_i = 1'b0;
  localparam logic c_sel_d = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cpu_mem_bridge_mem_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arb
// Purpose  : Pending/priority selection between fetch and data, plus the
//            per-cycle done flags that drive the pipeline stall request.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_arb
  import cpu_mem_bridge_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_inst_req_en,
  input  logic i_data_req_en,
  input  logic i_set_done_i,
  input  logic i_set_done_d,
  output logic o_stallreq,
  output logic o_pend_any,
  output logic o_pick_sel
);

  logic r_done_i;
  logic r_done_d;
  logic w_pend_i;
  logic w_pend_d;

  assign w_pend_i   = i_inst_req_en & ~r_done_i;
  assign w_pend_d   = i_data_req_en & ~r_done_d;
  assign o_pend_any = w_pend_i | w_pend_d;
  assign o_stallreq = rst & o_pend_any;
  assign o_pick_sel = w_pend_d ? c_sel_d : c_sel_i;

  // A cycle without stall means the core advanced; both requests are new.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_done_i <= 1'b0;
      r_done_d <= 1'b0;
    end else if (!o_stallreq) begin
      r_done_i <= 1'b0;
      r_done_d <= 1'b0;
    end else begin
      if (i_set_done_i) r_done_i <= 1'b1;
      if (i_set_done_d) r_done_d <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_bridge
// Purpose  : Serialises CPU fetch and data requests onto one request/response
//            bus, stalling the pipeline until each is served.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_mem_bridge
  import cpu_mem_bridge_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_req_en,
  input  logic [AW-1:0]   inst_req_addr,
  output logic [DW-1:0]   inst_rdata,
  input  logic            data_req_en,
  input  logic [DW/8-1:0] data_req_wen,
  input  logic [AW-1:0]   data_req_addr,
  input  logic [DW-1:0]   data_req_wdata,
  output logic [DW-1:0]   data_rdata,
  output logic            stallreq,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic            bus_req_wr,
  output logic [DW/8-1:0] bus_req_wstrb,
  output logic [AW-1:0]   bus_req_addr,
  output logic [DW-1:0]   bus_req_wdata,
  input  logic            bus_resp_valid,
  input  logic [DW-1:0]   bus_resp_rdata
);

  localparam int c_sw = DW / 8;

  logic [c_state_w-1:0] r_state;
  logic [c_state_w-1:0] w_state_nxt;
  logic                 r_sel;
  logic                 r_wr;
  logic [c_sw-1:0]      r_wstrb;
  logic [AW-1:0]        r_addr;
  logic [DW-1:0]        r_wdata;
  logic [DW-1:0]        r_inst_rdata;
  logic [DW-1:0]        r_data_rdata;

  logic w_pend_any;
  logic w_pick_sel;
  logic w_issue;
  logic w_capture;
  logic w_set_done_i;
  logic w_set_done_d;
  logic w_req_valid;

  mem_req_arb u_arb (
    .clk           (clk),
    .rst           (rst),
    .i_inst_req_en (inst_req_en),
    .i_data_req_en (data_req_en),
    .i_set_done_i  (w_set_done_i),
    .i_set_done_d  (w_set_done_d),
    .o_stallreq    (stallreq),
    .o_pend_any    (w_pend_any),
    .o_pick_sel    (w_pick_sel)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= c_st_idle;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_pend_any)     w_state_nxt = c_st_req;
      c_st_req:  if (bus_req_ready)  w_state_nxt = c_st_resp;
      c_st_resp: if (bus_resp_valid) w_state_nxt = c_st_idle;
      default:                       w_state_nxt = c_st_idle;
    endcase
  end

  // Responses outside RESP belong to no live request and are ignored.
  always_comb begin
    w_issue      = (r_state == c_st_idle) & w_pend_any;
    w_capture    = (r_state == c_st_resp) & bus_resp_valid;
    w_set_done_i = w_capture & (r_sel == c_sel_i);
    w_set_done_d = w_capture & (r_sel == c_sel_d);
    w_req_valid  = (r_state == c_st_req);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sel        <= c_sel_i;
      r_wr         <= 1'b0;
      r_wstrb      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      if (w_issue) begin
        r_sel <= w_pick_sel;
        if (w_pick_sel == c_sel_d) begin
          r_wr    <= |data_req_wen;
          r_wstrb <= data_req_wen;
          r_addr  <= data_req_addr;
          r_wdata <= data_req_wdata;
        end else begin
          r_wr    <= 1'b0;
          r_wstrb <= '0;
          r_addr  <= inst_req_addr;
          r_wdata <= '0;
        end
      end
      if (w_set_done_i)          r_inst_rdata <= bus_resp_rdata;
      if (w_set_done_d && !r_wr) r_data_rdata <= bus_resp_rdata;
    end
  end

  // Every output reads as zero for as long as reset is held low.
  assign bus_req_valid = rst & w_req_valid;
  assign bus_req_wr    = rst & r_wr;
  assign bus_req_wstrb = rst ? r_wstrb      : '0;
  assign bus_req_addr  = rst ? r_addr       : '0;
  assign bus_req_wdata = rst ? r_wdata      : '0;
  assign inst_rdata    = rst ? r_inst_rdata : '0;
  assign data_rdata    = rst ? r_data_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_mem_bridge
// Purpose  : Directed and random checks of cpu_mem_bridge against a memory
//            model and a variable-latency bus slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req_en = 1'b0;
  logic [31:0] inst_req_addr = '0;
  logic [31:0] inst_rdata;
  logic        data_req_en = 1'b0;
  logic [3:0]  data_req_wen = '0;
  logic [31:0] data_req_addr = '0;
  logic [31:0] data_req_wdata = '0;
  logic [31:0] data_rdata;
  logic        stallreq;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic        bus_req_wr;
  logic [3:0]  bus_req_wstrb;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic        bus_resp_valid = 1'b0;
  logic [31:0] bus_resp_rdata = '0;

  cpu_mem_bridge #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req_en(inst_req_en), .inst_req_addr(inst_req_addr), .inst_rdata(inst_rdata),
    .data_req_en(data_req_en), .data_req_wen(data_req_wen), .data_req_addr(data_req_addr),
    .data_req_wdata(data_req_wdata), .data_rdata(data_rdata), .stallreq(stallreq),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_wr(bus_req_wr),
    .bus_req_wstrb(bus_req_wstrb), .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata),
    .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Slave configuration (written by the stimulus only) and request log (slave only).
  int          cfg_ready_low = 0;
  int          cfg_resp_delay = 0;
  int          inject_req = 0;
  int          inject_ack = 0;
  int          hold_viol = 0;
  logic [31:0] log_addr[$];
  logic        log_wr[$];
  logic [3:0]  log_strb[$];
  logic [31:0] log_wdata[$];
  logic [31:0] slv_mem [logic [31:0]];

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C01_0001;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : mem_init(a);
  endfunction

  initial begin : slave
    int          s_wait;
    int          s_resp;
    bit          s_in_req;
    logic [31:0] s_rdata;
    logic [31:0] snap_addr, snap_wdata, m;
    logic        snap_wr;
    logic [3:0]  snap_strb;
    s_wait = 0; s_resp = -1; s_in_req = 0; s_rdata = '0;
    snap_addr = '0; snap_wdata = '0; snap_wr = 0; snap_strb = '0;
    forever begin
      @(negedge clk);
      bus_resp_valid = 1'b0;
      bus_req_ready  = 1'b0;
      if (!rst) begin
        s_in_req = 0;
        s_resp   = -1;
      end else begin
        if (s_resp == 0) begin
          bus_resp_valid = 1'b1;
          bus_resp_rdata = s_rdata;
          s_resp = -1;
        end else if (s_resp > 0) begin
          s_resp--;
        end
        if (inject_req != inject_ack) begin
          bus_resp_valid = 1'b1;
          bus_resp_rdata = 32'hDEAD_BEEF;
          inject_ack++;
        end
        if (bus_req_valid) begin
          if (!s_in_req) begin
            s_in_req = 1; s_wait = cfg_ready_low;
            snap_addr = bus_req_addr; snap_wdata = bus_req_wdata;
            snap_wr = bus_req_wr; snap_strb = bus_req_wstrb;
          end else if (bus_req_addr !== snap_addr || bus_req_wdata !== snap_wdata ||
                       bus_req_wr !== snap_wr || bus_req_wstrb !== snap_strb) begin
            hold_viol++;
          end
          if (s_wait > 0) begin
            s_wait--;
          end else begin
            bus_req_ready = 1'b1;
            s_in_req = 0;
            log_addr.push_back(bus_req_addr);
            log_wr.push_back(bus_req_wr);
            log_strb.push_back(bus_req_wstrb);
            log_wdata.push_back(bus_req_wdata);
            if (bus_req_wr) begin
              m = slv_rd(bus_req_addr);
              for (int b = 0; b < 4; b++)
                if (bus_req_wstrb[b]) m[8*b +: 8] = bus_req_wdata[8*b +: 8];
              slv_mem[bus_req_addr] = m;
              s_rdata = 32'hFFFF_FFFF;
            end else begin
              s_rdata = slv_rd(bus_req_addr);
            end
            s_resp = cfg_resp_delay;
          end
        end
      end
    end
  end

  // Reference model: memory contents and the rdata values the core should see.
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_i = '0;
  logic [31:0] exp_d = '0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    inst_req_en = 1'b0;
    data_req_en = 1'b0;
  endtask

  task automatic op(input string tag, input bit ie, input logic [31:0] ia, input bit de,
                    input logic [3:0] wen, input logic [31:0] da, input logic [31:0] wd,
                    input int rl, input int rdly);
    int          stalls, base, ntx, idx;
    logic [31:0] m;
    cfg_ready_low  = rl;
    cfg_resp_delay = rdly;
    base = log_addr.size();
    ntx  = (ie ? 1 : 0) + (de ? 1 : 0);
    if (de) begin
      if (wen == 4'b0000) exp_d = ref_rd(da);
      else begin
        m = ref_rd(da);
        for (int b = 0; b < 4; b++) if (wen[b]) m[8*b +: 8] = wd[8*b +: 8];
        ref_mem[da] = m;
      end
    end
    if (ie) exp_i = ref_rd(ia);
    @(posedge clk); #1;
    inst_req_en = ie; inst_req_addr = ia;
    data_req_en = de; data_req_wen = wen; data_req_addr = da; data_req_wdata = wd;
    #1;
    stalls = 0;
    while (stallreq === 1'b1 && stalls < 200) begin
      stalls++;
      @(posedge clk); #2;
    end
    chk({tag, ".stall"}, 32'(stalls), 32'(ntx * (3 + rl + rdly)));
    chk({tag, ".inst_rdata"}, inst_rdata, exp_i);
    chk({tag, ".data_rdata"}, data_rdata, exp_d);
    chk({tag, ".nreq"}, 32'(log_addr.size() - base), 32'(ntx));
    if (log_addr.size() == base + ntx) begin
      idx = base;
      if (de) begin
        chk({tag, ".d_addr"}, log_addr[idx], da);
        chk({tag, ".d_wr"}, 32'(log_wr[idx]), 32'(wen != 4'b0000));
        chk({tag, ".d_strb"}, 32'(log_strb[idx]), 32'(wen));
        if (wen != 4'b0000) chk({tag, ".d_wdata"}, log_wdata[idx], wd);
        idx++;
      end
      if (ie) begin
        chk({tag, ".i_addr"}, log_addr[idx], ia);
        chk({tag, ".i_wr"}, 32'(log_wr[idx]), 32'd0);
        chk({tag, ".i_strb"}, 32'(log_strb[idx]), 32'd0);
      end
    end
    if (stalls >= 200) begin
      inst_req_en = 1'b0; data_req_en = 1'b0;
      rst = 1'b0; @(posedge clk); #1; rst = 1'b1;
      exp_i = '0; exp_d = '0;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : stim
    int          base;
    logic [3:0]  wen;
    bit          ie, de;
    // Reset values with both enables asserted
    inst_req_en = 1'b1; data_req_en = 1'b1; inst_req_addr = 32'hBFC0_0000;
    repeat (2) @(posedge clk);
    #2;
    chk("rst.stallreq", 32'(stallreq), 32'd0);
    chk("rst.valid", 32'(bus_req_valid), 32'd0);
    chk("rst.wr_strb", {27'd0, bus_req_wr, bus_req_wstrb}, 32'd0);
    chk("rst.addr", bus_req_addr, 32'd0);
    chk("rst.wdata", bus_req_wdata, 32'd0);
    chk("rst.inst_rdata", inst_rdata, 32'd0);
    chk("rst.data_rdata", data_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; inst_req_en = 1'b0; data_req_en = 1'b0;

    op("fetch", 1, 32'hBFC0_0000, 0, 4'b0000, 32'h0, 32'h0, 0, 0);
    chk("fetch.value", inst_rdata, 32'h3C01_0001);
    idle();
    op("fetch_data", 1, 32'hBFC0_0004, 1, 4'b0000, 32'h8000_0010, 32'h0, 0, 0);
    idle();
    op("store", 0, 32'h0, 1, 4'b0011, 32'h8000_0020, 32'h1234_5678, 0, 0);
    idle();
    op("load_back", 0, 32'h0, 1, 4'b0000, 32'h8000_0020, 32'h0, 0, 0);
    idle();
    op("backpressure", 1, 32'hBFC0_000C, 0, 4'b0000, 32'h0, 32'h0, 4, 0);
    chk("backpressure.hold", 32'(hold_viol), 32'd0);
    idle();
    op("resp_wait", 0, 32'h0, 1, 4'b0000, 32'h8000_0014, 32'h0, 0, 2);
    // Back-to-back: the next fetch follows in the cycle after completion
    op("b2b_first", 1, 32'hBFC0_0004, 0, 4'b0000, 32'h0, 32'h0, 0, 0);
    op("b2b_next", 1, 32'hBFC0_0008, 0, 4'b0000, 32'h0, 32'h0, 0, 0);
    idle();

    // Reset while a fetch waits in RESP, then a stray response
    base = log_addr.size();
    cfg_ready_low = 0; cfg_resp_delay = 20;
    @(posedge clk); #1;
    inst_req_en = 1'b1; inst_req_addr = 32'hBFC0_0010;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0; inst_req_en = 1'b0;
    #1;
    chk("midrst.stallreq", 32'(stallreq), 32'd0);
    chk("midrst.valid", 32'(bus_req_valid), 32'd0);
    @(posedge clk); #2;
    chk("midrst.inst_rdata", inst_rdata, 32'd0);
    chk("midrst.data_rdata", data_rdata, 32'd0);
    chk("midrst.addr", bus_req_addr, 32'd0);
    #1;
    rst = 1'b1; exp_i = '0; exp_d = '0; cfg_resp_delay = 0;
    inject_req++;
    repeat (3) @(posedge clk);
    #2;
    chk("stray.inst_rdata", inst_rdata, 32'd0);
    chk("stray.valid", 32'(bus_req_valid), 32'd0);
    chk("stray.nreq", 32'(log_addr.size() - base), 32'd1);
    op("after_rst", 1, 32'hBFC0_0014, 0, 4'b0000, 32'h0, 32'h0, 0, 0);

    for (int k = 0; k < 25; k++) begin
      ie  = $urandom_range(0, 1) == 1;
      de  = $urandom_range(0, 1) == 1;
      if (!ie && !de) ie = 1;
      wen = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
      op($sformatf("rnd%0d", k), ie, 32'hBFC0_0000 + 32'($urandom_range(0, 7) * 4),
         de, wen, 32'h8000_0000 + 32'($urandom_range(0, 7) * 4), $urandom(),
         int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) idle();
    end
    chk("final.hold", 32'(hold_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
